store_buffer: RTL and testbench

Store buffer sitting directly upstream of the data memory in the MEM stage. Stores from the pipeline are queued in a small in-order FIFO and drained into the memory's write port during cycles when no load needs the shared address port. Loads read memory combinationally, and the result is patched with any younger matching buffered store data, so the pipeline always sees program-order memory contents.

---
 rtl/store_buffer.sv | 131 +++++++++++++
 tb/tb_store_buffer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
// In-order store queue in front of the data memory. Stores are buffered and
// drained into the memory write port on cycles without a load; loads read
// memory combinationally and are patched with matching buffered store data so
// the pipeline always observes program-order memory contents.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   st_valid/st_byte/st_addr/st_data store request (byte or word)
//   st_ready                        buffer can accept a store (count < DEPTH)
//   ld_valid/ld_addr                load request
//   ld_data                         forwarded load result (combinational)
//   mem_addr/mem_wdata              shared memory address / write data
//   mem_write/mem_write_eight       word / byte write strobes
//   mem_rdata                       combinational memory read data
//   empty                           no buffered stores
// ---------------------------------------------------------------------------
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  input  logic        st_byte,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic [31:0] ld_data,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_write_eight,
  input  logic [31:0] mem_rdata,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]    r_addr [DEPTH];
  logic [31:0]    r_data [DEPTH];
  logic [DEPTH-1:0] r_byte;
  logic [AW-1:0]  r_head;
  logic [AW-1:0]  r_tail;
  logic [CW-1:0]  r_count;

  logic           w_push;
  logic           w_drain;
  logic           w_has;
  logic [AW-1:0]  w_idx;
  logic [31:0]    w_fwd;

  // Status flags come only from the registered count.
  assign st_ready = (r_count < CW'(DEPTH));
  assign empty    = (r_count == {CW{1'b0}});
  assign w_has    = !empty;
  assign w_push   = st_valid && st_ready;
  assign w_drain  = !ld_valid && w_has;

  // Memory port arbitration: a load owns the port, otherwise the head drains.
  always_comb begin
    mem_addr        = 32'h0000_0000;
    mem_wdata       = 32'h0000_0000;
    mem_write       = 1'b0;
    mem_write_eight = 1'b0;
    if (ld_valid) begin
      mem_addr = ld_addr;
    end else if (w_has) begin
      mem_addr        = r_addr[r_head];
      mem_wdata       = r_data[r_head];
      mem_write       = !r_byte[r_head];
      mem_write_eight = r_byte[r_head];
    end else begin
      mem_addr = 32'h0000_0000;
    end
  end

  // Load forwarding: walk oldest to youngest so the youngest match wins.
  always_comb begin
    w_fwd = mem_rdata;
    w_idx = {AW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + AW'(i);
      if ((CW'(i) < r_count) && (r_addr[w_idx] == ld_addr)) begin
        if (r_byte[w_idx]) begin
          w_fwd[7:0] = r_data[w_idx][7:0];
        end else begin
          w_fwd = r_data[w_idx];
        end
      end else begin
        w_fwd = w_fwd;
      end
    end
  end

  assign ld_data = w_fwd;

  // Entry storage: written on push, deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= st_addr;
      r_data[r_tail] <= st_data;
      r_byte[r_tail] <= st_byte;
    end
  end

  // Pointers and occupancy; reset discards every buffered store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= {AW{1'b0}};
      r_tail  <= {AW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_tail <= r_tail + AW'(1);
      end
      if (w_drain) begin
        r_head <= r_head + AW'(1);
      end
      case ({w_push, w_drain})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        b;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_byte;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_write_eight;
  logic [31:0] mem_rdata;
  logic        empty;

  logic [31:0] mem [64];
  ent_t        sb_q[$];
  ent_t        mon_e;
  int          n_checks;
  int          n_pass;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_byte(st_byte), .st_addr(st_addr), .st_data(st_data),
    .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_write_eight(mem_write_eight), .mem_rdata(mem_rdata), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-indexed data memory; all test addresses differ only in bits [7:2].
  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[7:2]] = mem_wdata;
    else if (mem_write_eight) mem[mem_addr[7:2]][7:0] = mem_wdata[7:0];
  end

  // Scoreboard: every memory write must be the oldest accepted store.
  always @(negedge clk) begin
    if (mem_write || mem_write_eight) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL drain_unexpected: got addr=%h data=%h w=%b b=%b, required no write",
                 mem_addr, mem_wdata, mem_write, mem_write_eight);
      end else begin
        mon_e = sb_q.pop_front();
        if (mem_addr !== mon_e.a || mem_wdata !== mon_e.d ||
            mem_write_eight !== mon_e.b || mem_write !== !mon_e.b)
          $display("FAIL drain_order: got addr=%h data=%h w=%b b=%b, required addr=%h data=%h byte=%b",
                   mem_addr, mem_wdata, mem_write, mem_write_eight, mon_e.a, mon_e.d, mon_e.b);
        else n_pass++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sv, input logic sb, input logic [31:0] sa,
                       input logic [31:0] sd, input logic lv, input logic [31:0] la);
    st_valid = sv; st_byte = sb; st_addr = sa; st_data = sd;
    ld_valid = lv; ld_addr = la;
    if (sv && sb_q.size() < DEPTH) sb_q.push_back('{a: sa, d: sd, b: sb});
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    mem[0] = 32'h0BAD_F00D;
    mem[9] = 32'h1234_5678;
    step(); step();
    n_checks++; if (st_ready !== 1'b1) $display("FAIL reset_st_ready: got %b required 1", st_ready); else n_pass++;
    n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b required 1", empty); else n_pass++;
    n_checks++; if ({mem_write, mem_write_eight} !== 2'b00) $display("FAIL reset_strobes: got %b%b required 00", mem_write, mem_write_eight); else n_pass++;
    n_checks++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %h required 0", mem_addr); else n_pass++;
    rst_n = 1'b1;
    step();
    n_checks++; if (ld_data !== 32'h0BAD_F00D) $display("FAIL idle_ld_data: got %h required 0badf00d", ld_data); else n_pass++;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FF24);
    #1;
    n_checks++; if (ld_data !== 32'h1234_5678) $display("FAIL idle_load: got %h required 12345678", ld_data); else n_pass++;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_basic_drain();
    step();
    n_checks++; if (st_ready !== 1'b1) $display("FAIL basic_st_ready: got %b required 1", st_ready); else n_pass++;
    drive(1'b1, 1'b0, 32'hFFFF_FF10, 32'hDEAD_BEEF, 1'b0, 32'h0);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1;
    n_checks++; if (mem_addr !== 32'hFFFF_FF10) $display("FAIL basic_addr: got %h required ffffff10", mem_addr); else n_pass++;
    n_checks++; if (mem_wdata !== 32'hDEAD_BEEF) $display("FAIL basic_wdata: got %h required deadbeef", mem_wdata); else n_pass++;
    n_checks++; if ({mem_write, mem_write_eight} !== 2'b10) $display("FAIL basic_strobe: got %b%b required 10", mem_write, mem_write_eight); else n_pass++;
    step();
    n_checks++; if (empty !== 1'b1) $display("FAIL basic_empty: got %b required 1", empty); else n_pass++;
    n_checks++; if (mem[4] !== 32'hDEAD_BEEF) $display("FAIL basic_mem: got %h required deadbeef", mem[4]); else n_pass++;
  endtask

  task automatic test_full();
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if (st_ready !== (k < 4)) $display("FAIL full_st_ready_%0d: got %b required %b", k, st_ready, (k < 4));
      else n_pass++;
      drive(1'b1, 1'b0, 32'hFFFF_FF40 + 32'(4 * k), 32'hC0DE_0000 + 32'(k), 1'b1, 32'hFFFF_FF80);
    end
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FF80);
    #1;
    n_checks++; if (st_ready !== 1'b0) $display("FAIL full_held: got %b required 0", st_ready); else n_pass++;
    n_checks++; if ({mem_write, mem_write_eight} !== 2'b00) $display("FAIL full_load_blocks: got %b%b required 00", mem_write, mem_write_eight); else n_pass++;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    for (int j = 0; j < 4; j++) begin
      #1;
      n_checks++;
      if (mem_write !== 1'b1 || mem_addr !== 32'hFFFF_FF40 + 32'(4 * j))
        $display("FAIL full_drain_%0d: got w=%b addr=%h required w=1 addr=%h", j, mem_write, mem_addr, 32'hFFFF_FF40 + 32'(4 * j));
      else n_pass++;
      step();
    end
    n_checks++; if (empty !== 1'b1 || mem_write !== 1'b0) $display("FAIL full_drained: got empty=%b w=%b required 1 0", empty, mem_write); else n_pass++;
    n_checks++; if (mem[20] !== 32'h0) $display("FAIL full_dropped: got %h required 0", mem[20]); else n_pass++;
  endtask

  task automatic test_forward();
    mem[8] = 32'h1122_3344;
    step();
    drive(1'b1, 1'b0, 32'hFFFF_FF20, 32'hAABB_CCDD, 1'b1, 32'hFFFF_FF20);
    step();
    drive(1'b1, 1'b1, 32'hFFFF_FF20, 32'h0000_00EE, 1'b1, 32'hFFFF_FF20);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FF20);
    #1;
    n_checks++; if (ld_data !== 32'hAABB_CCEE) $display("FAIL fwd_merge: got %h required aabbccee", ld_data); else n_pass++;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FF24);
    #1;
    n_checks++; if (ld_data !== 32'h1234_5678) $display("FAIL fwd_nomatch: got %h required 12345678", ld_data); else n_pass++;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step(); step(); step();
    n_checks++; if (mem[8] !== 32'hAABB_CCEE) $display("FAIL fwd_mem: got %h required aabbccee", mem[8]); else n_pass++;
    n_checks++; if (empty !== 1'b1) $display("FAIL fwd_empty: got %b required 1", empty); else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 10; k++) begin
      step();
      n_checks++;
      if (st_ready !== 1'b1 || empty !== (k == 0))
        $display("FAIL b2b_count_%0d: got ready=%b empty=%b required 1 %b", k, st_ready, empty, (k == 0));
      else n_pass++;
      drive(1'b1, 1'b0, 32'hFFFF_FF60 + 32'(4 * k), 32'hB0B0_0000 + 32'(k), 1'b0, 32'h0);
    end
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    n_checks++; if (empty !== 1'b0) $display("FAIL b2b_last: got empty=%b required 0", empty); else n_pass++;
    step();
    n_checks++; if (empty !== 1'b1) $display("FAIL b2b_empty: got %b required 1", empty); else n_pass++;
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if (mem[24 + k] !== 32'hB0B0_0000 + 32'(k))
        $display("FAIL b2b_mem_%0d: got %h required %h", k, mem[24 + k], 32'hB0B0_0000 + 32'(k));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      step();
      drive(1'b1, 1'b0, 32'hFFFF_FFA0 + 32'(4 * k), 32'hFEED_0000 + 32'(k), 1'b1, 32'hFFFF_FF80);
    end
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FF80);
    n_checks++; if (empty !== 1'b0) $display("FAIL mid_buffered: got empty=%b required 0", empty); else n_pass++;
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1;
    n_checks++; if (empty !== 1'b1 || st_ready !== 1'b1) $display("FAIL mid_reset_flags: got empty=%b ready=%b required 1 1", empty, st_ready); else n_pass++;
    n_checks++; if ({mem_write, mem_write_eight} !== 2'b00) $display("FAIL mid_reset_strobes: got %b%b required 00", mem_write, mem_write_eight); else n_pass++;
    step();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFA0);
    #1;
    n_checks++; if (ld_data !== 32'h0) $display("FAIL mid_no_forward: got %h required 0", ld_data); else n_pass++;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    for (int k = 0; k < 5; k++) step();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (mem[40 + k] !== 32'h0) $display("FAIL mid_mem_%0d: got %h required 0", k, mem[40 + k]);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    test_reset();
    test_basic_drain();
    test_full();
    test_forward();
    test_back_to_back();
    test_reset_mid();
    step();
    n_checks++; if (sb_q.size() != 0) $display("FAIL sb_leftover: got %0d pending required 0", sb_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
